prog_counter_alu: RTL
=====================

Name: prog_counter_alu

Overview:
Parametrised successor of the fixed-sequence counter/ALU datapath. The ALU opcode sequence is held in a writable program store instead of being hard-coded in FSM states; it is run under a start/done handshake with a programmable length and loadable initial operands. Each executed step updates the accumulator w with (w op b) and post-increments the counter b. Serves as the reusable sequenced-arithmetic engine for the HW5 datapath and its bench.

Parameters:
WIDTH, 4, data width of w, b and s; all arithmetic is modulo 2^WIDTH.
DEPTH, 16, number of program entries (>=2); AW = $clog2(DEPTH), LW = $clog2(DEPTH+1).

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-low reset
prog_we  in  1  write enable for program store
prog_addr  in  AW  program write address
prog_op  in  3  opcode to write
start  in  1  single-cycle request to run a program
len  in  LW  number of steps to execute (0..DEPTH), sampled with start
init_w  in  WIDTH  accumulator start value, sampled with start
init_b  in  WIDTH  counter start value, sampled with start
busy  out  1  high while state is RUN
done  out  1  one-cycle pulse when a run completes
w_out  out  WIDTH  accumulator register
b_out  out  WIDTH  counter register
s_out  out  WIDTH  combinational ALU result for current op_out, w, b
op_out  out  3  opcode being executed; 3'd7 when not in RUN
step_out  out  AW  current program index
dz_flag  out  1  sticky divide-by-zero indicator

Behaviour:
- Opcodes: 0 add, 1 sub, 2 mul (low WIDTH bits), 3 div (unsigned quotient), 4 and, 5 or, 6 xor, 7 nop (s = w). Add/sub wrap mod 2^WIDTH.
- Div by zero (op 3, b==0): s = all ones; dz_flag set when that step executes.
- Reset (reset==0, async): state IDLE; w, b, step_out = 0; busy, done, dz_flag = 0. All program entries = 7 (nop).
- Program store: on edge with prog_we=1 and state IDLE or DONE, prog[prog_addr] <= prog_op. Writes while busy are ignored. prog_addr >= DEPTH is ignored.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 and len>0: w<=init_w, b<=init_b, step<=0, dz_flag<=0, steps_left<=len, next RUN.
- IDLE, start=1 and len==0: w/b loaded and dz_flag cleared as above; next DONE (no step executed).
- IDLE, start=0: hold.
- RUN (every cycle): op_out = prog[step]; w<=s_out; b<=b+1 (wraps); step<=step+1; steps_left decrements.
  - When steps_left==1, next state is DONE.
  - A len-step run therefore occupies exactly len RUN cycles.
- DONE: done=1 for exactly one cycle, busy=0, w/b hold the final values; next IDLE.
- start is ignored in RUN and DONE (no queuing).
- Final w and b hold in IDLE until the next accepted start.
- op 7 inside a program still increments b.
- Reset asserted mid-run aborts immediately: no done pulse; the program store is reinitialised to nop.

Test Plan:
1. WIDTH=4. Program ops 0,5,2,1,3,0,0,6,0,4 at addr 0..9; start with len=10, init_w=0, init_b=1 -> busy for 10 cycles; per-step w = 1,3,9,5,1,7,14,6,15,10; done pulses once; final w_out=10, b_out=11, dz_flag=0.
2. Divide by zero: prog[0]=3; start with len=1, init_w=9, init_b=0 -> w_out=15, b_out=1, dz_flag=1. A following start (len=1, prog[0]=0, init_b=2) clears dz_flag.
3. Wrap: prog[0]=0, prog[1]=2; len=2, init_w=15, init_b=1 -> after step 0 w=0, b=2; after step 1 w=0, b=3. Then init_w=15, init_b=15 with add only (len=1) -> w=14, b=0.
4. len=0 start -> done the cycle after start, busy never asserted, w=init_w, b=init_b.
5. prog_we pulses and extra start pulses during RUN of a len=4 run -> program contents unchanged (readback via op_out on the next run); exactly one done pulse.
6. Assert reset (low) during step 2 of a len=8 run -> w, b, busy, done, dz_flag at 0 asynchronously; no done pulse; op_out=7; subsequent run of len=1 without reprogramming leaves w=init_w (nop).

Source files
------------

// File: rtl/prog_counter_alu.sv
// Sequenced arithmetic engine: executes a stored opcode program, updating
// accumulator w with (w op b) and post-incrementing counter b on each step.
module prog_counter_alu #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [2:0]       prog_op,
    input  logic             start,
    input  logic [LW-1:0]    len,
    input  logic [WIDTH-1:0] init_w,
    input  logic [WIDTH-1:0] init_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] w_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] s_out,
    output logic [2:0]       op_out,
    output logic [AW-1:0]    step_out,
    output logic             dz_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_NOP = 3'd7;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [AW-1:0]    step_q, step_d;
    logic [LW-1:0]    left_q, left_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       prog_q [DEPTH];
    logic [2:0]       prog_d [DEPTH];
    logic [2:0]       op_cur;
    logic [WIDTH-1:0] alu_res;

    // Opcode evaluation; a zero divisor yields all ones rather than trapping.
    function automatic logic [WIDTH-1:0] alu_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   res;
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (op)
            3'd0:    res = a + b;
            3'd1:    res = a - b;
            3'd2:    res = prod[WIDTH-1:0];
            3'd3:    res = (b == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : (a / b);
            3'd4:    res = a & b;
            3'd5:    res = a | b;
            3'd6:    res = a ^ b;
            default: res = a;
        endcase
        return res;
    endfunction

    // Opcode presented to the ALU: the current program entry while running.
    always_comb begin
        op_cur = OP_NOP;
        if (state_q == ST_RUN) begin
            op_cur = prog_q[step_q];
        end else begin
            op_cur = OP_NOP;
        end
    end

    // ALU result for the current opcode and operands.
    always_comb begin
        alu_res = alu_f(op_cur, w_q, b_q);
    end

    // Program store update: writes are accepted only outside a run.
    always_comb begin
        prog_d = prog_q;
        if (prog_we && (state_q != ST_RUN) && (32'(prog_addr) < DEPTH)) begin
            prog_d[prog_addr] = prog_op;
        end else begin
            prog_d = prog_q;
        end
    end

    // Sequencer next-state and datapath update.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        b_d     = b_q;
        step_d  = step_q;
        left_d  = left_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d    = init_w;
                    b_d    = init_b;
                    step_d = {AW{1'b0}};
                    dz_d   = 1'b0;
                    left_d = len;
                    if (len != {LW{1'b0}}) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_d    = alu_res;
                b_d    = b_q + WIDTH'(1);
                step_d = step_q + AW'(1);
                left_d = left_q - LW'(1);
                if ((op_cur == OP_DIV) && (b_q == {WIDTH{1'b0}})) begin
                    dz_d = 1'b1;
                end else begin
                    dz_d = dz_q;
                end
                if (left_q == LW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State registers; reset also restores every program entry to nop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            w_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            step_q  <= {AW{1'b0}};
            left_q  <= {LW{1'b0}};
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                prog_q[i] <= OP_NOP;
            end
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            b_q     <= b_d;
            step_q  <= step_d;
            left_q  <= left_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prog_q  <= prog_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign w_out    = w_q;
    assign b_out    = b_q;
    assign s_out    = alu_res;
    assign op_out   = op_cur;
    assign step_out = step_q;
    assign dz_flag  = dz_q;

endmodule
